// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: datapath widths
// and the arbitration FSM state encoding.
package regfile_wr_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_POS_W  = 4;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Round-robin priority pick: returns a one-hot grant for the lowest set
// request bit at or after ptr, wrapping to index 0. Purely combinational.
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [N-1:0] hi_gnt;
    logic [N-1:0] lo_gnt;

    // Scan downward so the last hit is the lowest index; requests at or
    // above the pointer take precedence over the wrapped-around ones.
    always_comb begin
        hi_gnt = '0;
        lo_gnt = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                if (j >= int'(ptr)) begin
                    hi_gnt    = '0;
                    hi_gnt[j] = 1'b1;
                end else begin
                    lo_gnt    = '0;
                    lo_gnt[j] = 1'b1;
                end
            end
        end
        gnt = (hi_gnt != '0) ? hi_gnt : lo_gnt;
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write arbiter: NUM_REQ requesters share one write port.
// Round-robin arbitration with per-requester burst lock, a global hold,
// and a registered one-beat write output with a saturating write counter.
// Optional feature: define REGFILE_WR_ARBITER_R0_DROP_EN to acknowledge
// but silently drop writes to address 0.
//
// Handshake: a transfer happens on a rising edge where req_valid_i[k] and
// req_ready_o[k] are both high. req_ready_o is at most one-hot, depends
// combinationally on the current inputs, and is zero during hold/reset.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 16
) (
    input  logic                          clk_i,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_lock_i,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*REG_DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ*REG_POS_W-1:0]  req_pos_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          wr_hold_i,
    output logic                          RegWrite_o,
    output logic [REG_ADDR_W-1:0]         RDaddr_o,
    output logic [REG_DATA_W-1:0]         RDdata_o,
    output logic [REG_POS_W-1:0]          is_pos_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          locked_o,
    output logic [CNT_W-1:0]              wr_count_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e             state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [NUM_REQ-1:0]     owner;
    logic [NUM_REQ-1:0]     pick_gnt;
    logic                   accept;
    logic                   issue;
    logic [PTR_W-1:0]       win_idx;
    logic [PTR_W-1:0]       next_ptr;
    logic                   win_lock;
    logic                   owner_lock;
    logic                   owner_valid;
    logic [REG_ADDR_W-1:0]  sel_addr;
    logic [REG_DATA_W-1:0]  sel_data;
    logic [REG_POS_W-1:0]   sel_pos;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (req_valid_i),
        .ptr (rr_ptr),
        .gnt (pick_gnt)
    );

    // Ready: round-robin pick in ARB, only the owner in LOCKED, none on hold/reset.
    always_comb begin
        req_ready_o = '0;
        if (!reset && !wr_hold_i) begin
            if (state == ARB) begin
                req_ready_o = pick_gnt;
            end else begin
                req_ready_o = owner & req_valid_i;
            end
        end
    end

    // Select the winner's index and payload from the one-hot ready vector.
    always_comb begin
        win_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_pos  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ready_o[k]) begin
                win_idx  = PTR_W'(k);
                sel_addr = req_addr_i[k*REG_ADDR_W +: REG_ADDR_W];
                sel_data = req_data_i[k*REG_DATA_W +: REG_DATA_W];
                sel_pos  = req_pos_i[k*REG_POS_W +: REG_POS_W];
            end
        end
    end

    assign accept      = |req_ready_o;
    assign win_lock    = |(req_ready_o & req_lock_i);
    assign owner_lock  = |(owner & req_lock_i);
    assign owner_valid = |(owner & req_valid_i);
    assign next_ptr    = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : PTR_W'(win_idx + 1'b1);

`ifdef REGFILE_WR_ARBITER_R0_DROP_EN
    // Address 0 is hard-wired zero in the register file: accept, but do not write.
    assign issue = accept && (sel_addr != '0);
`else
    assign issue = accept;
`endif

    // Arbitration FSM: pointer advance, lock entry/exit; frozen while on hold.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state    <= ARB;
            rr_ptr   <= '0;
            owner    <= '0;
            locked_o <= 1'b0;
        end else if (!wr_hold_i) begin
            case (state)
                ARB: begin
                    if (accept) begin
                        rr_ptr <= next_ptr;
                        if (win_lock) begin
                            state    <= LOCKED;
                            owner    <= req_ready_o;
                            locked_o <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (!owner_lock && (accept || !owner_valid)) begin
                        state    <= ARB;
                        owner    <= '0;
                        locked_o <= 1'b0;
                    end
                end
                default: begin
                    state    <= ARB;
                    owner    <= '0;
                    locked_o <= 1'b0;
                end
            endcase
        end
    end

    // Write port: one-cycle pulse per issued transfer; payload holds when idle.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            RegWrite_o <= 1'b0;
            RDaddr_o   <= '0;
            RDdata_o   <= '0;
            is_pos_o   <= '0;
            grant_o    <= '0;
            wr_count_o <= '0;
        end else begin
            RegWrite_o <= issue;
            grant_o    <= issue ? req_ready_o : '0;
            if (issue) begin
                RDaddr_o <= sel_addr;
                RDdata_o <= sel_data;
                is_pos_o <= sel_pos;
                if (wr_count_o != {CNT_W{1'b1}}) begin
                    wr_count_o <= wr_count_o + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed vectors, expected write beats
// queued by the driver and checked by an independent output monitor.
module tb_regfile_wr_arbiter;

    localparam int NR = 3;
    localparam int W  = 44;   // {grant[2:0], pos[3:0], addr[4:0], data[31:0]}

    logic          clk_i = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] req_valid_i = '0;
    logic [NR-1:0] req_lock_i  = '0;
    logic [NR*5-1:0]  req_addr_i = '0;
    logic [NR*32-1:0] req_data_i = '0;
    logic [NR*4-1:0]  req_pos_i  = '0;
    logic          wr_hold_i = 1'b0;

    logic [NR-1:0] req_ready_o;
    logic          RegWrite_o;
    logic [4:0]    RDaddr_o;
    logic [31:0]   RDdata_o;
    logic [3:0]    is_pos_o;
    logic [NR-1:0] grant_o;
    logic          locked_o;
    logic [15:0]   wr_count_o;

    logic [NR-1:0] s_ready;
    logic          s_regwrite;
    logic [4:0]    s_addr;
    logic [31:0]   s_data;
    logic [3:0]    s_pos;
    logic [NR-1:0] s_grant;
    logic          s_locked;
    logic [3:0]    s_count;

    logic [W-1:0]  exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            beat_id = 0;
    logic [4:0]    addr_v[NR];
    logic [31:0]   data_v[NR];
    logic [3:0]    pos_v[NR];

    regfile_wr_arbiter #(.NUM_REQ(NR), .CNT_W(16)) dut (
        .clk_i(clk_i), .reset(reset), .req_valid_i(req_valid_i), .req_lock_i(req_lock_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_pos_i(req_pos_i),
        .req_ready_o(req_ready_o), .wr_hold_i(wr_hold_i), .RegWrite_o(RegWrite_o),
        .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o), .is_pos_o(is_pos_o), .grant_o(grant_o),
        .locked_o(locked_o), .wr_count_o(wr_count_o)
    );

    regfile_wr_arbiter #(.NUM_REQ(NR), .CNT_W(4)) dut_sat (
        .clk_i(clk_i), .reset(reset), .req_valid_i(req_valid_i), .req_lock_i(req_lock_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_pos_i(req_pos_i),
        .req_ready_o(s_ready), .wr_hold_i(wr_hold_i), .RegWrite_o(s_regwrite),
        .RDaddr_o(s_addr), .RDdata_o(s_data), .is_pos_o(s_pos), .grant_o(s_grant),
        .locked_o(s_locked), .wr_count_o(s_count)
    );

    // Clock and watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Driver: apply one cycle of inputs, check ready/locked before the edge,
    // and queue the write beat that edge should produce.
    task automatic drive(input logic [2:0] valid, input logic [2:0] lock, input logic hold,
                         input int mode, input logic [2:0] exp_rdy, input logic exp_lk);
        int  a;
        int  w;
        logic drop;
        @(posedge clk_i);
        #1;
        reset = 1'b0;
        beat_id++;
        for (int k = 0; k < NR; k++) begin
            a = 1 + ((beat_id * 3 + k * 5) % 31);
            addr_v[k] = 5'(a);
            data_v[k] = 32'hA5000000 + 32'(beat_id * 256 + k);
            pos_v[k]  = 4'(beat_id + k);
            if (mode == 1 && k == 0) begin
                addr_v[k] = 5'd0;
                data_v[k] = 32'hDEADBEEF;
            end
            if (mode == 2) addr_v[k] = 5'd9;
            req_addr_i[k*5 +: 5]   = addr_v[k];
            req_data_i[k*32 +: 32] = data_v[k];
            req_pos_i[k*4 +: 4]    = pos_v[k];
        end
        req_valid_i = valid;
        req_lock_i  = lock;
        wr_hold_i   = hold;
        @(negedge clk_i);
        check("ready", {61'd0, req_ready_o}, {61'd0, exp_rdy});
        check("locked", {63'd0, locked_o}, {63'd0, exp_lk});
        if (exp_rdy != 3'b000) begin
            w = exp_rdy[0] ? 0 : (exp_rdy[1] ? 1 : 2);
`ifdef REGFILE_WR_ARBITER_R0_DROP_EN
            drop = (addr_v[w] == 5'd0);
`else
            drop = 1'b0;
`endif
            if (!drop) exp_q.push_back({exp_rdy, pos_v[w], addr_v[w], data_v[w]});
        end
    endtask

    task automatic apply_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            reset = 1'b1;
            @(negedge clk_i);
            check("ready_in_reset", {61'd0, req_ready_o}, 64'd0);
        end
    endtask

    // Monitor / scoreboard: compare every cycle's registered outputs
    initial begin : monitor
        logic         prev_rst;
        logic [W-1:0] e;
        logic [W-1:0] last;
        logic [15:0]  exp_cnt;
        logic [3:0]   exp_cnt_s;
        prev_rst  = 1'b1;
        last      = '0;
        exp_cnt   = '0;
        exp_cnt_s = '0;
        forever begin
            @(posedge clk_i);
            #2;
            if (prev_rst) begin
                exp_cnt   = '0;
                exp_cnt_s = '0;
                last      = '0;
                exp_q.delete();
                check("reset_write_port", {20'd0, RegWrite_o, grant_o, is_pos_o, RDaddr_o, RDdata_o}, 64'd0);
                check("reset_locked", {63'd0, locked_o}, 64'd0);
            end else if (RegWrite_o) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got RegWrite_o=1 addr=%0h data=%0h required no write",
                             RDaddr_o, RDdata_o);
                end else begin
                    e = exp_q.pop_front();
                    check("write_beat", {20'd0, grant_o, is_pos_o, RDaddr_o, RDdata_o}, {20'd0, e});
                    last = e;
                    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                    if (exp_cnt_s != 4'hF) exp_cnt_s = exp_cnt_s + 4'd1;
                end
            end else begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_write: got RegWrite_o=0 required write %0h", e);
                end
                check("idle_hold", {20'd0, grant_o, is_pos_o, RDaddr_o, RDdata_o},
                      {20'd0, 3'b000, last[40:0]});
            end
            check("wr_count", {48'd0, wr_count_o}, {48'd0, exp_cnt});
            check("wr_count_sat4", {60'd0, s_count}, {60'd0, exp_cnt_s});
            prev_rst = reset;
        end
    end

    // Stimulus
    initial begin : stim
        logic [2:0] g;
        apply_reset(2);

        // All requesters valid: round robin 0,1,2 back to back, count reaches 3
        drive(3'b111, 3'b000, 1'b0, 0, 3'b001, 1'b0);
        drive(3'b111, 3'b000, 1'b0, 0, 3'b010, 1'b0);
        drive(3'b111, 3'b000, 1'b0, 0, 3'b100, 1'b0);
        drive(3'b000, 3'b000, 1'b0, 0, 3'b000, 1'b0);

        // Pointer to 1, then requester 1 holds a 4-beat lock; next grant is 2
        drive(3'b001, 3'b000, 1'b0, 0, 3'b001, 1'b0);
        drive(3'b111, 3'b010, 1'b0, 0, 3'b010, 1'b0);
        drive(3'b111, 3'b010, 1'b0, 0, 3'b010, 1'b1);
        drive(3'b111, 3'b010, 1'b0, 0, 3'b010, 1'b1);
        drive(3'b111, 3'b000, 1'b0, 0, 3'b010, 1'b1);
        drive(3'b111, 3'b000, 1'b0, 0, 3'b100, 1'b0);

        // Hold for two cycles, then resume from the unchanged pointer (0)
        drive(3'b111, 3'b000, 1'b1, 0, 3'b000, 1'b0);
        drive(3'b111, 3'b000, 1'b1, 0, 3'b000, 1'b0);
        drive(3'b111, 3'b000, 1'b0, 0, 3'b001, 1'b0);
        drive(3'b111, 3'b000, 1'b0, 0, 3'b010, 1'b0);

        // Wrap-around from pointer 2, then single requester at pointer-1
        drive(3'b011, 3'b000, 1'b0, 0, 3'b001, 1'b0);
        drive(3'b100, 3'b000, 1'b0, 0, 3'b100, 1'b0);

        // Same address from two requesters issues in grant order
        drive(3'b111, 3'b000, 1'b0, 2, 3'b001, 1'b0);
        drive(3'b111, 3'b000, 1'b0, 2, 3'b010, 1'b0);

        // Requester 0 writes address 0 with DEADBEEF
        drive(3'b001, 3'b000, 1'b0, 1, 3'b001, 1'b0);
        drive(3'b000, 3'b000, 1'b0, 0, 3'b000, 1'b0);

        // Reset in the middle of a lock; first grant afterwards is lowest valid index
        drive(3'b110, 3'b010, 1'b0, 0, 3'b010, 1'b0);
        drive(3'b111, 3'b010, 1'b0, 0, 3'b010, 1'b1);
        apply_reset(2);
        drive(3'b110, 3'b000, 1'b0, 0, 3'b010, 1'b0);

        // 20 back-to-back writes: the 4-bit counter must saturate at F
        for (int i = 0; i < 20; i++) begin
            g = 3'b001 << ((2 + i) % 3);
            drive(3'b111, 3'b000, 1'b0, 0, g, 1'b0);
        end
        for (int i = 0; i < 3; i++) drive(3'b000, 3'b000, 1'b0, 0, 3'b000, 1'b0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("sat_final", {60'd0, s_count}, 64'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of write requesters sharing the register-file write port.
REQ-002 Parameter CNT_W, default 16: width of the write counter.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk_i  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester write request.
- req_lock_i  in  NUM_REQ  per-requester burst lock; keeps the grant while asserted.
- req_addr_i  in  NUM_REQ*5  packed destination addresses; requester k at bits [5k+4:5k].
- req_data_i  in  NUM_REQ*32  packed write data.
- req_pos_i  in  NUM_REQ*4  packed position tags.
- req_ready_o  out  NUM_REQ  one-hot accept; a transfer occurs when valid and ready are both high.
- wr_hold_i  in  1  freezes all grants while high.
- RegWrite_o  out  1  write enable to the register file.
- RDaddr_o  out  5  write address to the register file.
- RDdata_o  out  32  write data to the register file.
- is_pos_o  out  4  position tag to the register file.
- grant_o  out  NUM_REQ  one-hot owner of the current output beat.
- locked_o  out  1  high while in state LOCKED.
- wr_count_o  out  CNT_W  saturating count of writes issued.

Function
REQ-004 At most one req_ready_o bit SHALL be high per cycle; req_ready_o SHALL be all-zero while wr_hold_i or reset is high.
REQ-005 In state ARB, the winner SHALL be the lowest index at or after rr_ptr, wrapping modulo NUM_REQ, among asserted req_valid_i bits.
REQ-006 On an accept in ARB, rr_ptr SHALL become (winner+1) mod NUM_REQ.
REQ-007 On an accept in ARB with the winner's req_lock_i high, the FSM SHALL go to LOCKED and record the owner.
REQ-008 In LOCKED, only the owner SHALL be eligible for ready; rr_ptr SHALL be unchanged.
REQ-009 The FSM SHALL return from LOCKED to ARB in the cycle after the owner presents req_lock_i low, either on an accept or while req_valid_i is low.
REQ-010 wr_hold_i SHALL NOT change FSM state or rr_ptr.
REQ-011 Latency: a transfer accepted at edge N SHALL present RegWrite_o=1 and the captured addr/data/pos/grant from edge N until edge N+1, exactly one cycle per transfer. The register file captures on the falling edge of that cycle.
REQ-012 With no accept, RegWrite_o and grant_o SHALL be 0. RDaddr_o, RDdata_o and is_pos_o SHALL hold their last values.
REQ-013 wr_count_o SHALL increment by 1 for each RegWrite_o pulse and saturate at all-ones.
REQ-014 Back-to-back accepts, including from different requesters, SHALL produce RegWrite_o high on consecutive cycles with no bubble.
REQ-015 The arbiter SHALL NOT compare or merge addresses; two writes to the same address SHALL issue in grant order.

Reset
REQ-016 When reset is high at a clock edge, the block SHALL set FSM=ARB, rr_ptr=0, RegWrite_o=0, RDaddr_o=0, RDdata_o=0, is_pos_o=0, grant_o=0, locked_o=0 and wr_count_o=0.
REQ-017 A request in flight or a lock held when reset is applied SHALL be discarded; the requester must re-present it.

Configuration
REQ-018 With macro REGFILE_WR_ARBITER_R0_DROP_EN defined, accepted transfers with address 0 SHALL be acknowledged (ready high) but SHALL NOT assert RegWrite_o or increment wr_count_o.
REQ-019 Without REGFILE_WR_ARBITER_R0_DROP_EN, address 0 SHALL be written like any other address.

Structure
REQ-020 The shared package SHALL hold REG_ADDR_W=5, REG_DATA_W=32, REG_POS_W=4 and the FSM state enum {ARB, LOCKED}.
REQ-021 The round-robin priority pick SHALL be one sub-module, rr_pick: combinational, taking the request vector and pointer and returning a one-hot grant. All state SHALL live in the top module.

Verification
REQ-022 The bench SHALL cover these scenarios, one line each (stimulus -> required response):
- Reset, then valid=3'b111 held for 3 cycles -> grants 0, 1, 2 in order; RegWrite_o high for 3 consecutive cycles; wr_count_o=3.
- Requester 1 asserts lock with valid for 4 beats while requesters 0 and 2 are valid -> four grants to 1 in a row, locked_o high; the next grant goes to 2.
- wr_hold_i high for 2 cycles with all valid -> ready=0, RegWrite_o=0; after release, arbitration resumes from the unchanged rr_ptr.
- Requester 0 writes addr=0, data=32'hDEADBEEF -> with the macro: ready pulses, RegWrite_o stays 0; without the macro: RegWrite_o=1, RDaddr_o=0.
- Reset asserted mid-lock -> the next cycle shows all outputs 0 and FSM=ARB; the first grant after reset goes to the lowest valid index.
- wr_count_o preset near saturation using CNT_W=4, then 20 writes -> wr_count_o stops at 4'hF.
